// File: rtl/srport_ctrl_pkg.sv
// Shared definitions for the SR write-port / read-port-2 controller:
// default widths, SSP location, FSM encoding, adjust op and requester IDs.
package srport_ctrl_pkg;

    localparam int SR_DATA_W   = 24;
    localparam int SR_ADDR_W   = 4;
    localparam logic [SR_ADDR_W-1:0] INDEX_SSP = 4'd2;
    localparam int DBG_MAX_DEF = 3;

    // Controller sequencing: idle arbitration, then the two SSP adjust phases
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADJ_READ  = 2'd1,
        ST_ADJ_WRITE = 2'd2
    } port_state_t;

    // SSP adjust direction: push moves the stack down, pop moves it up
    typedef enum logic {
        ADJ_PUSH = 1'b0,
        ADJ_POP  = 1'b1
    } adj_op_t;

    // Identity of the requester granted in the current cycle
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WB   = 2'd1,
        REQ_ADJ  = 2'd2,
        REQ_DBG  = 2'd3
    } req_id_t;

endpackage

// File: rtl/srport_ctrl_arb.sv
// Priority select for the SR write port with a starvation guard for debug:
// after DBG_MAX consecutive losses debug jumps to the top of the order.
module sr_arb_prio
    import srport_ctrl_pkg::*;
#(
    parameter int DBG_MAX = DBG_MAX_DEF
) (
    input  logic    iw_clk,
    input  logic    iw_rst,
    input  logic    iw_enable,
    input  logic    iw_wb_valid,
    input  logic    iw_adj_valid,
    input  logic    iw_dbg_valid,
    output req_id_t ow_grant
);

    localparam logic [1:0] LOSS_MAX = 2'(DBG_MAX);

    logic [1:0] loss_cnt_reg;
    logic [1:0] loss_cnt_next;

    // Grant selection: starved debug first, else writeback > adjust > debug
    always_comb begin
        ow_grant = REQ_NONE;
        if (iw_enable) begin
            if (iw_dbg_valid && (loss_cnt_reg == LOSS_MAX)) begin
                ow_grant = REQ_DBG;
            end else if (iw_wb_valid) begin
                ow_grant = REQ_WB;
            end else if (iw_adj_valid) begin
                ow_grant = REQ_ADJ;
            end else if (iw_dbg_valid) begin
                ow_grant = REQ_DBG;
            end
        end
    end

    // Loss counter update: clear on debug grant, count debug losses while arbitrating
    always_comb begin
        loss_cnt_next = loss_cnt_reg;
        if (ow_grant == REQ_DBG) begin
            loss_cnt_next = 2'd0;
        end else if (iw_enable && iw_dbg_valid && (loss_cnt_reg != LOSS_MAX)) begin
            loss_cnt_next = loss_cnt_reg + 2'd1;
        end
    end

    // Loss counter register
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            loss_cnt_reg <= 2'd0;
        end else begin
            loss_cnt_reg <= loss_cnt_next;
        end
    end

endmodule

// File: rtl/srport_ctrl.sv
// Owner of the SR file write port and read port 2. Arbitrates writeback,
// debug and SSP-adjust requesters, registers the winning write, and runs the
// read-then-write sequence that moves SSP by a signed delta.
module srport_ctrl
    import srport_ctrl_pkg::*;
#(
    parameter int                 DATA_W    = SR_DATA_W,
    parameter int                 ADDR_W    = SR_ADDR_W,
    parameter logic [ADDR_W-1:0]  SSP_INDEX = ADDR_W'(INDEX_SSP),
    parameter int                 DBG_MAX   = DBG_MAX_DEF
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_wb_valid,
    output logic              ow_wb_ready,
    input  logic [ADDR_W-1:0] iw_wb_addr,
    input  logic [DATA_W-1:0] iw_wb_data,
    input  logic              iw_dbg_valid,
    output logic              ow_dbg_ready,
    input  logic [ADDR_W-1:0] iw_dbg_addr,
    input  logic [DATA_W-1:0] iw_dbg_data,
    input  logic              iw_adj_valid,
    output logic              ow_adj_ready,
    input  logic              iw_adj_pop,
    input  logic [DATA_W-1:0] iw_adj_delta,
    output logic              ow_adj_done,
    output logic [DATA_W-1:0] ow_adj_old,
    output logic [DATA_W-1:0] ow_adj_new,
    output logic              ow_adj_wrap,
    output logic [ADDR_W-1:0] ow_sr_write_addr,
    output logic [DATA_W-1:0] ow_sr_write_data,
    output logic              ow_sr_write_enable,
    output logic [ADDR_W-1:0] ow_sr_read_addr2,
    input  logic [DATA_W-1:0] iw_sr_read_data2
);

    port_state_t       state_reg;
    port_state_t       state_next;
    req_id_t           grant;
    logic              arb_enable;
    adj_op_t           adj_op_reg;
    logic [DATA_W-1:0] adj_delta_reg;
    logic [DATA_W:0]   adj_sum;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              done_reg;
    logic [DATA_W-1:0] old_reg;
    logic [DATA_W-1:0] new_reg;
    logic              wrap_reg;

    // Arbitration only runs in IDLE, and never while reset is held
    assign arb_enable = (state_reg == ST_IDLE) && !iw_rst;

    sr_arb_prio #(
        .DBG_MAX (DBG_MAX)
    ) u_arb (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_enable    (arb_enable),
        .iw_wb_valid  (iw_wb_valid),
        .iw_adj_valid (iw_adj_valid),
        .iw_dbg_valid (iw_dbg_valid),
        .ow_grant     (grant)
    );

    assign ow_wb_ready  = (grant == REQ_WB);
    assign ow_dbg_ready = (grant == REQ_DBG);
    assign ow_adj_ready = (grant == REQ_ADJ);

    // Extra top bit carries the borrow (push) or carry (pop) out of the SSP math
    assign adj_sum = (adj_op_reg == ADJ_POP)
                   ? ({1'b0, iw_sr_read_data2} + {1'b0, adj_delta_reg})
                   : ({1'b0, iw_sr_read_data2} - {1'b0, adj_delta_reg});

    // Next-state logic: an adjust grant starts the fixed two-cycle sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (grant == REQ_ADJ) state_next = ST_ADJ_READ;
            ST_ADJ_READ:  state_next = ST_ADJ_WRITE;
            ST_ADJ_WRITE: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Write/adjust datapath: the write is registered one cycle after its
    // source (grant or SSP read), so the ADJ_WRITE cycle carries the SSP write
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            adj_op_reg    <= ADJ_PUSH;
            adj_delta_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            done_reg      <= 1'b0;
            old_reg       <= '0;
            new_reg       <= '0;
            wrap_reg      <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (grant)
                REQ_WB: begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= iw_wb_addr;
                    wr_data_reg <= iw_wb_data;
                end
                REQ_DBG: begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= iw_dbg_addr;
                    wr_data_reg <= iw_dbg_data;
                end
                REQ_ADJ: begin
                    adj_op_reg    <= adj_op_t'(iw_adj_pop);
                    adj_delta_reg <= iw_adj_delta;
                end
                default: ;
            endcase
            if (state_reg == ST_ADJ_READ) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= SSP_INDEX;
                wr_data_reg <= adj_sum[DATA_W-1:0];
                done_reg    <= 1'b1;
                old_reg     <= iw_sr_read_data2;
                new_reg     <= adj_sum[DATA_W-1:0];
                wrap_reg    <= adj_sum[DATA_W];
            end
        end
    end

    assign ow_sr_write_enable = wr_en_reg;
    assign ow_sr_write_addr   = wr_addr_reg;
    assign ow_sr_write_data   = wr_data_reg;
    assign ow_adj_done        = done_reg;
    assign ow_adj_old         = old_reg;
    assign ow_adj_new         = new_reg;
    assign ow_adj_wrap        = wrap_reg;
    assign ow_sr_read_addr2   = (state_reg == ST_ADJ_READ) ? SSP_INDEX : '0;

endmodule

// File: tb/tb_srport_ctrl.sv
// Directed bench for srport_ctrl with a behavioural SR file and a write scoreboard.
module tb_srport_ctrl;
    import srport_ctrl_pkg::*;

    localparam int DW = 24;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_valid = 1'b0, dbg_valid = 1'b0, adj_valid = 1'b0;
    logic          wb_ready, dbg_ready, adj_ready;
    logic [AW-1:0] wb_addr = '0, dbg_addr = '0;
    logic [DW-1:0] wb_data = '0, dbg_data = '0, adj_delta = '0;
    logic          adj_pop = 1'b0;
    logic          adj_done, adj_wrap;
    logic [DW-1:0] adj_old, adj_new;
    logic [AW-1:0] sr_waddr, sr_raddr2;
    logic [DW-1:0] sr_wdata, sr_rdata2;
    logic          sr_we;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            is_adj;
        logic [DW-1:0] old;
        bit            wrap;
    } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] exp_ssp = 24'h000FFF;

    always #5 clk = ~clk;

    srport_ctrl dut (
        .iw_clk             (clk),
        .iw_rst             (rst),
        .iw_wb_valid        (wb_valid),
        .ow_wb_ready        (wb_ready),
        .iw_wb_addr         (wb_addr),
        .iw_wb_data         (wb_data),
        .iw_dbg_valid       (dbg_valid),
        .ow_dbg_ready       (dbg_ready),
        .iw_dbg_addr        (dbg_addr),
        .iw_dbg_data        (dbg_data),
        .iw_adj_valid       (adj_valid),
        .ow_adj_ready       (adj_ready),
        .iw_adj_pop         (adj_pop),
        .iw_adj_delta       (adj_delta),
        .ow_adj_done        (adj_done),
        .ow_adj_old         (adj_old),
        .ow_adj_new         (adj_new),
        .ow_adj_wrap        (adj_wrap),
        .ow_sr_write_addr   (sr_waddr),
        .ow_sr_write_data   (sr_wdata),
        .ow_sr_write_enable (sr_we),
        .ow_sr_read_addr2   (sr_raddr2),
        .iw_sr_read_data2   (sr_rdata2)
    );

    // Behavioural SR file: SSP resets to 000FFF, combinational read port 2
    logic [DW-1:0] sr_mem [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) sr_mem[i] <= '0;
            sr_mem[INDEX_SSP] <= 24'h000FFF;
        end else if (sr_we) begin
            sr_mem[sr_waddr] <= sr_wdata;
        end
    end
    assign sr_rdata2 = sr_mem[sr_raddr2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back('{addr: a, data: d, is_adj: 1'b0, old: '0, wrap: 1'b0});
        if (a == INDEX_SSP) exp_ssp = d;
    endtask

    task automatic push_adj(input logic pop, input logic [DW-1:0] delta);
        logic [DW:0] r;
        r = pop ? ({1'b0, exp_ssp} + {1'b0, delta}) : ({1'b0, exp_ssp} - {1'b0, delta});
        sb.push_back('{addr: INDEX_SSP, data: r[DW-1:0], is_adj: 1'b1, old: exp_ssp, wrap: r[DW]});
        exp_ssp = r[DW-1:0];
    endtask

    // Scoreboard monitor: every SR write must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (sr_we) begin
                chk("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("write addr=%0h data=%h done=%0b old=%h new=%h wrap=%0b",
                             sr_waddr, sr_wdata, adj_done, adj_old, adj_new, adj_wrap);
                    chk("write_addr", 32'(sr_waddr), 32'(e.addr));
                    chk("write_data", 32'(sr_wdata), 32'(e.data));
                    chk("adj_done", 32'(adj_done), 32'(e.is_adj));
                    if (e.is_adj) begin
                        chk("adj_old", 32'(adj_old), 32'(e.old));
                        chk("adj_new", 32'(adj_new), 32'(e.data));
                        chk("adj_wrap", 32'(adj_wrap), 32'(e.wrap));
                    end
                end
            end else begin
                chk("done_without_write", 32'(adj_done), 32'd0);
            end
        end
    end

    function automatic logic rdy(input int k);
        case (k)
            0:       return wb_ready;
            1:       return adj_ready;
            default: return dbg_ready;
        endcase
    endfunction

    task automatic wait_ready(input int k, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy(k)) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        wb_addr = a; wb_data = d; wb_valid = 1'b1;
        wait_ready(0, "wb_ready_timeout", ok);
        if (ok) push_write(a, d);
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    task automatic do_adj(input logic pop, input logic [DW-1:0] delta);
        bit ok;
        adj_pop = pop; adj_delta = delta; adj_valid = 1'b1;
        wait_ready(1, "adj_ready_timeout", ok);
        if (ok) push_adj(pop, delta);
        @(posedge clk); #1;
        adj_valid = 1'b0;
        @(negedge clk);
        chk("adj_read_addr2", 32'(sr_raddr2), 32'(INDEX_SSP));
        chk("adj_read_no_we", 32'(sr_we), 32'd0);
        @(negedge clk);
        chk("adj_done_latency", 32'(adj_done), 32'd1);
        chk("adj_write_raddr2", 32'(sr_raddr2), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string p);
        chk({p, "_wb_ready"}, 32'(wb_ready), 32'd0);
        chk({p, "_dbg_ready"}, 32'(dbg_ready), 32'd0);
        chk({p, "_adj_ready"}, 32'(adj_ready), 32'd0);
        chk({p, "_we"}, 32'(sr_we), 32'd0);
        chk({p, "_waddr"}, 32'(sr_waddr), 32'd0);
        chk({p, "_wdata"}, 32'(sr_wdata), 32'd0);
        chk({p, "_raddr2"}, 32'(sr_raddr2), 32'd0);
        chk({p, "_done"}, 32'(adj_done), 32'd0);
        chk({p, "_old"}, 32'(adj_old), 32'd0);
        chk({p, "_new"}, 32'(adj_new), 32'd0);
        chk({p, "_wrap"}, 32'(adj_wrap), 32'd0);
    endtask

    initial begin
        bit ok;
        logic exp_dbg;

        // Reset with every requester valid: readies must stay low
        wb_valid = 1'b1; dbg_valid = 1'b1; adj_valid = 1'b1;
        @(negedge clk);
        chk_outputs_zero("reset");
        wb_valid = 1'b0; dbg_valid = 1'b0; adj_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Push 3 from reset SSP 000FFF -> 000FFC
        do_adj(1'b0, 24'd3);
        // Pop 2 from FFFFFF wraps to 000001
        do_wb(INDEX_SSP, 24'hFFFFFF);
        do_adj(1'b1, 24'd2);
        // Writeback to SSP immediately followed by adjust sees the new value
        do_wb(INDEX_SSP, 24'h123456);
        do_adj(1'b0, 24'h000056);

        // Writeback and debug contending every cycle: 3 wb grants then debug
        wb_addr = 4'd5; wb_data = 24'h000100;
        dbg_addr = 4'd7; dbg_data = 24'h00D000;
        wb_valid = 1'b1; dbg_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_dbg = ((i % 4) == 3);
            chk("fair_wb_ready", 32'(wb_ready), 32'(!exp_dbg));
            chk("fair_dbg_ready", 32'(dbg_ready), 32'(exp_dbg));
            if (exp_dbg) push_write(dbg_addr, dbg_data);
            else         push_write(wb_addr, wb_data);
            @(posedge clk); #1;
            if (exp_dbg) dbg_data = dbg_data + 24'd1;
            else         wb_data = wb_data + 24'd1;
        end
        wb_valid = 1'b0; dbg_valid = 1'b0;
        @(posedge clk); #1;

        // Adjust and writeback together: writeback first, adjust next, then busy
        wb_addr = 4'd3; wb_data = 24'hABCDEF; wb_valid = 1'b1;
        adj_pop = 1'b1; adj_delta = 24'd16; adj_valid = 1'b1;
        @(negedge clk);
        chk("both_wb_ready", 32'(wb_ready), 32'd1);
        chk("both_adj_ready", 32'(adj_ready), 32'd0);
        push_write(wb_addr, wb_data);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("both_adj_ready2", 32'(adj_ready), 32'd1);
        push_adj(1'b1, 24'd16);
        @(posedge clk); #1;
        adj_valid = 1'b0;
        wb_addr = 4'd4; wb_data = 24'h000042; wb_valid = 1'b1;
        @(negedge clk);
        chk("busy_read_wb_ready", 32'(wb_ready), 32'd0);
        @(negedge clk);
        chk("busy_write_wb_ready", 32'(wb_ready), 32'd0);
        chk("busy_write_done", 32'(adj_done), 32'd1);
        @(negedge clk);
        chk("after_adj_wb_ready", 32'(wb_ready), 32'd1);
        push_write(wb_addr, wb_data);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during ADJ_READ: no write, no done, outputs cleared
        adj_pop = 1'b0; adj_delta = 24'd5; adj_valid = 1'b1;
        wait_ready(1, "rst_adj_ready_timeout", ok);
        @(posedge clk); #1;
        adj_valid = 1'b0;
        chk("rst_mid_in_read", 32'(sr_raddr2), 32'(INDEX_SSP));
        #1 rst = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        @(negedge clk);
        chk("rst_mid_we", 32'(sr_we), 32'd0);
        chk("rst_mid_done", 32'(adj_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ssp = 24'h000FFF;
        repeat (3) @(posedge clk);
        #1;
        do_adj(1'b0, 24'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
